// File: rtl/frame_draw_ctrl_pkg.sv
// Shared screen geometry, pixel bundle and frame FSM encoding for the frame drawer.
package frame_draw_ctrl_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COL_W    = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int LANES    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BG    = 2'd1,
        TILES = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic             plot;
    } pix_t;

    // Bottom clip works on the un-truncated 8-bit row so rows past 127 never wrap back on screen.
    function automatic logic row_visible(input logic [X_W-1:0] y_sum);
        return y_sum <= 8'(SCREEN_H - 1);
    endfunction

endpackage

// File: rtl/frame_draw_ctrl_tile_raster.sv
// Tile pixel generator: snapshots lane state, walks 4 lanes x 128 pixels, one per cycle.
// The registered pixel always matches the index held in lane_idx/pix_cnt (loaded on start).
module tile_raster
    import frame_draw_ctrl_pkg::*;
#(
    parameter int               LANE_X0    = 12,
    parameter int               LANE_PITCH = 40,
    parameter int               TILE_W     = 16,
    parameter int               TILE_H     = 8,
    parameter logic [COL_W-1:0] TILE_COL   = 3'b111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        run,
    input  logic [3:0]  lane_active,
    input  logic [27:0] lane_y,
    output pix_t        pix,
    output logic        last
);

    localparam int PIX_LAST = TILE_W * TILE_H - 1;

    logic [3:0]  act_snap;
    logic [27:0] y_snap;
    logic [1:0]  lane_idx;
    logic [6:0]  pix_cnt;

    logic [1:0]  lane_nxt;
    logic [6:0]  cnt_nxt;
    logic [3:0]  act_src;
    logic [27:0] y_src;
    logic [6:0]  y_top;
    logic [3:0]  dx;
    logic [2:0]  dy;
    logic [7:0]  x_sum;
    logic [7:0]  y_sum;
    pix_t        pix_nxt;

    // On start the snapshot is being captured this very cycle, so pixel 0 reads the live inputs.
    always_comb begin
        act_src = act_snap;
        y_src   = y_snap;
        {lane_nxt, cnt_nxt} = {lane_idx, pix_cnt} + 9'd1;
        if (start) begin
            act_src  = lane_active;
            y_src    = lane_y;
            lane_nxt = '0;
            cnt_nxt  = '0;
        end
        y_top = y_src[7*lane_nxt +: 7];
        dx    = cnt_nxt[3:0];
        dy    = cnt_nxt[6:4];
        x_sum = 8'(LANE_X0) + 8'(LANE_PITCH) * {6'b0, lane_nxt} + {4'b0, dx};
        y_sum = {1'b0, y_top} + {5'b0, dy};
        pix_nxt.col  = TILE_COL;
        pix_nxt.x    = x_sum;
        pix_nxt.y    = y_sum[6:0];
        pix_nxt.plot = act_src[lane_nxt] && row_visible(y_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_snap <= '0;
            y_snap   <= '0;
            lane_idx <= '0;
            pix_cnt  <= '0;
            pix      <= '0;
        end else if (start || run) begin
            lane_idx <= lane_nxt;
            pix_cnt  <= cnt_nxt;
            pix      <= pix_nxt;
            if (start) begin
                act_snap <= lane_active;
                y_snap   <= lane_y;
            end
        end
    end

    assign last = (lane_idx == 2'd3) && (pix_cnt == 7'(PIX_LAST));

endmodule

// File: rtl/frame_draw_ctrl.sv
// Frame sequencer: background pass, then four lane tiles, then a one-cycle done pulse.
// vga_* is a registered stream (1 cycle) selected by state; IDLE/DONE force it to zero.
module frame_draw_ctrl
    import frame_draw_ctrl_pkg::*;
#(
    parameter int               LANE_X0    = 12,
    parameter int               LANE_PITCH = 40,
    parameter int               TILE_W     = 16,
    parameter int               TILE_H     = 8,
    parameter logic [COL_W-1:0] TILE_COL   = 3'b111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [3:0]       lane_active,
    input  logic [27:0]      lane_y,
    output logic             bg_enable,
    input  logic [COL_W-1:0] bg_col,
    input  logic [X_W-1:0]   bg_x,
    input  logic [Y_W-1:0]   bg_y,
    input  logic             bg_plot,
    input  logic             bg_done,
    output logic [COL_W-1:0] vga_col,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic             vga_plot,
    output logic             frame_done,
    output logic             frame_overrun
);

    state_t state, state_nxt;
    pix_t   bg_pix;
    pix_t   tile_pix;
    pix_t   vga_pix;
    logic   tile_start;
    logic   tile_last;

    assign tile_start = (state == BG) && bg_done;

    tile_raster #(
        .LANE_X0    (LANE_X0),
        .LANE_PITCH (LANE_PITCH),
        .TILE_W     (TILE_W),
        .TILE_H     (TILE_H),
        .TILE_COL   (TILE_COL)
    ) u_tile_raster (
        .clk         (clk),
        .reset       (reset),
        .start       (tile_start),
        .run         (state == TILES),
        .lane_active (lane_active),
        .lane_y      (lane_y),
        .pix         (tile_pix),
        .last        (tile_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bg_pix        <= '0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_nxt;
            bg_pix        <= {bg_col, bg_x, bg_y, bg_plot};
            frame_overrun <= frame_tick && (state != IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        bg_enable  = 1'b0;
        frame_done = 1'b0;
        vga_pix    = '0;
        case (state)
            IDLE: begin
                if (frame_tick) state_nxt = BG;
            end
            BG: begin
                bg_enable = !bg_done;
                vga_pix   = bg_pix;
                if (bg_done) state_nxt = TILES;
            end
            TILES: begin
                vga_pix = tile_pix;
                if (tile_last) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign vga_col  = vga_pix.col;
    assign vga_x    = vga_pix.x;
    assign vga_y    = vga_pix.y;
    assign vga_plot = vga_pix.plot;

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Directed bench for frame_draw_ctrl: background mirror, tile raster, clipping, overrun and reset cases.
module tb_frame_draw_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [3:0]  lane_active;
    logic [27:0] lane_y;
    logic        bg_enable;
    logic [2:0]  bg_col;
    logic [7:0]  bg_x;
    logic [6:0]  bg_y;
    logic        bg_plot;
    logic        bg_done;
    logic [2:0]  vga_col;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic        vga_plot;
    logic        frame_done;
    logic        frame_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    frame_draw_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .lane_active   (lane_active),
        .lane_y        (lane_y),
        .bg_enable     (bg_enable),
        .bg_col        (bg_col),
        .bg_x          (bg_x),
        .bg_y          (bg_y),
        .bg_plot       (bg_plot),
        .bg_done       (bg_done),
        .vga_col       (vga_col),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_plot      (vga_plot),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [3:0] act, input logic [27:0] ys, input int bg_cycles);
        lane_active = act;
        lane_y      = ys;
        bg_done     = 1'b0;
        frame_tick  = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (bg_cycles) cyc();
        bg_done = 1'b1;
        cyc();
        bg_done = 1'b0;
    endtask

    // Walks the 512 TILES cycles against the raster formula; optionally pulses frame_tick at index inj.
    task automatic scan_tiles(input logic [3:0] act, input logic [27:0] ys, input int inj,
                              output int nplot, output int errs, output int xmin, output int xmax,
                              output int ymin, output int ymax, output int wraps, output int ovr,
                              output logic [15:0] first_px, output logic [15:0] last_px);
        nplot = 0; errs = 0; xmin = 255; xmax = 0; ymin = 127; ymax = 0; wraps = 0; ovr = 0;
        first_px = '0; last_px = '0;
        for (int k = 0; k < 512; k++) begin
            int         lane;
            int         ex;
            int         ey;
            logic       ep;
            logic [6:0] ytop;
            logic [31:0] exv;
            logic [31:0] eyv;
            frame_tick = (k == inj);
            #4;
            lane = k / 128;
            ytop = ys[7*lane +: 7];
            ex   = (12 + 40 * lane + (k % 16)) % 256;
            ey   = int'(ytop) + (k % 128) / 16;
            ep   = act[lane] && (ey <= 119);
            exv  = ex;
            eyv  = ey;
            if (vga_x !== exv[7:0] || vga_y !== eyv[6:0] || vga_plot !== ep ||
                vga_col !== 3'b111 || frame_done !== 1'b0 || bg_enable !== 1'b0)
                errs++;
            if (frame_overrun) ovr++;
            if (act[lane] && vga_y < ytop) wraps++;
            if (vga_plot) begin
                nplot++;
                if (int'(vga_x) < xmin) xmin = vga_x;
                if (int'(vga_x) > xmax) xmax = vga_x;
                if (int'(vga_y) < ymin) ymin = vga_y;
                if (int'(vga_y) > ymax) ymax = vga_y;
            end
            if (k == 0)   first_px = {vga_x, vga_y, vga_plot};
            if (k == 511) last_px  = {vga_x, vga_y, vga_plot};
            cyc();
        end
        frame_tick = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int restart;
        #4;
        check({tag, "_done_pulse"}, frame_done, 1);
        check({tag, "_done_plot"}, vga_plot, 0);
        check({tag, "_done_bg_en"}, bg_enable, 0);
        cyc();
        #4;
        check({tag, "_done_drop"}, frame_done, 0);
        cyc();
        restart = 0;
        repeat (6) begin
            #4;
            if (bg_enable || frame_done || vga_plot) restart++;
            cyc();
        end
        check({tag, "_no_restart"}, restart, 0);
    endtask

    initial begin
        int nplot, errs, xmin, xmax, ymin, ymax, wraps, ovr, dn;
        logic [15:0] fpx, lpx;
        logic [18:0] prev_bg;
        logic [31:0] v;

        reset = 1'b1; frame_tick = 1'b0; lane_active = '0; lane_y = '0;
        bg_col = '0; bg_x = '0; bg_y = '0; bg_plot = 1'b0; bg_done = 1'b0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        #4;
        check("rst_outputs", {vga_col, vga_x, vga_y, vga_plot, bg_enable, frame_done, frame_overrun}, 0);
        frame_tick = 1'b0;
        reset = 1'b0;
        cyc();

        // Full frame, all lanes at row 0, long background pass
        lane_active = 4'hF; lane_y = '0;
        bg_col = 3'd5; bg_x = 8'hA5; bg_y = 7'h2C; bg_plot = 1'b1;
        prev_bg = {bg_col, bg_x, bg_y, bg_plot};
        frame_tick = 1'b1;
        #4;
        check("idle_bg_en", bg_enable, 0);
        cyc();
        frame_tick = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            v = i;
            bg_x = v[7:0]; bg_y = v[14:8] ^ v[6:0]; bg_col = v[2:0] ^ v[5:3]; bg_plot = v[1];
            #4;
            if (i < 64 || i == 32767) begin
                check("bg_mirror", {vga_col, vga_x, vga_y, vga_plot}, prev_bg);
                check("bg_enable", bg_enable, 1);
            end
            prev_bg = {bg_col, bg_x, bg_y, bg_plot};
            cyc();
        end
        bg_done = 1'b1;
        #4;
        check("bg_en_drop", bg_enable, 0);
        check("bg_mirror_last", {vga_col, vga_x, vga_y, vga_plot}, prev_bg);
        cyc();
        bg_done = 1'b0;
        scan_tiles(4'hF, 28'd0, -1, nplot, errs, xmin, xmax, ymin, ymax, wraps, ovr, fpx, lpx);
        check("a_errs", errs, 0);
        check("a_nplot", nplot, 512);
        check("a_first", fpx, {8'd12, 7'd0, 1'b1});
        check("a_last", lpx, {8'd147, 7'd7, 1'b1});
        finish_frame("a");

        // Only lane 2 at row 50; inputs scrambled after the snapshot
        start_frame(4'b0100, 28'd50 << 14, 10);
        lane_active = 4'hF; lane_y = 28'hFFF_FFFF;
        scan_tiles(4'b0100, 28'd50 << 14, -1, nplot, errs, xmin, xmax, ymin, ymax, wraps, ovr, fpx, lpx);
        check("b_errs", errs, 0);
        check("b_nplot", nplot, 128);
        check("b_xrange", {xmin[7:0], xmax[7:0]}, {8'd92, 8'd107});
        check("b_yrange", {ymin[7:0], ymax[7:0]}, {8'd50, 8'd57});
        finish_frame("b");

        // Lane 1 at row 116: bottom clipping
        start_frame(4'b0010, 28'd116 << 7, 4);
        scan_tiles(4'b0010, 28'd116 << 7, -1, nplot, errs, xmin, xmax, ymin, ymax, wraps, ovr, fpx, lpx);
        check("c_errs", errs, 0);
        check("c_nplot", nplot, 64);
        check("c_yrange", {ymin[7:0], ymax[7:0]}, {8'd116, 8'd119});
        check("c_xrange", {xmin[7:0], xmax[7:0]}, {8'd52, 8'd67});
        check("c_no_wrap", wraps, 0);
        finish_frame("c");

        // frame_tick arriving mid-TILES is dropped and flagged
        start_frame(4'hF, 28'd0, 3);
        scan_tiles(4'hF, 28'd0, 100, nplot, errs, xmin, xmax, ymin, ymax, wraps, ovr, fpx, lpx);
        check("d_errs", errs, 0);
        check("d_nplot", nplot, 512);
        check("d_overrun", ovr, 1);
        finish_frame("d");

        // Reset in the middle of TILES abandons the frame
        start_frame(4'hF, 28'd0, 2);
        repeat (200) cyc();
        reset = 1'b1;
        cyc();
        #4;
        check("e_rst_outputs", {vga_col, vga_x, vga_y, vga_plot, bg_enable, frame_done, frame_overrun}, 0);
        reset = 1'b0;
        cyc();
        dn = 0;
        repeat (600) begin
            #4;
            if (frame_done || bg_enable || vga_plot) dn++;
            cyc();
        end
        check("e_abandon", dn, 0);
        start_frame(4'b1001, (28'd20 << 21) | 28'd10, 5);
        scan_tiles(4'b1001, (28'd20 << 21) | 28'd10, -1, nplot, errs, xmin, xmax, ymin, ymax, wraps, ovr, fpx, lpx);
        check("e_errs", errs, 0);
        check("e_nplot", nplot, 256);
        finish_frame("e");

        // bg_done already high when the frame starts: one-cycle BG
        bg_done = 1'b1; lane_active = 4'b0001; lane_y = '0;
        repeat (3) cyc();
        frame_tick = 1'b1;
        #4;
        check("f_idle_bg_en", bg_enable, 0);
        cyc();
        frame_tick = 1'b0;
        #4;
        check("f_bg_one_cycle", bg_enable, 0);
        cyc();
        scan_tiles(4'b0001, 28'd0, -1, nplot, errs, xmin, xmax, ymin, ymax, wraps, ovr, fpx, lpx);
        check("f_errs", errs, 0);
        check("f_nplot", nplot, 128);
        check("f_first", fpx, {8'd12, 7'd0, 1'b1});
        bg_done = 1'b0;
        finish_frame("f");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
